// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between the
// instruction-fetch and load/store ports, with a per-transaction watchdog.
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int DATA_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_request,
    input  logic                  i_we_re,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic [DATA_W-1:0]     i_data_in,
    input  logic [DATA_W/8-1:0]   i_mask,
    output logic                  i_valid,
    output logic [DATA_W-1:0]     i_data_out,
    input  logic                  d_request,
    input  logic                  d_we_re,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic [DATA_W-1:0]     d_data_in,
    input  logic [DATA_W/8-1:0]   d_mask,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     d_data_out,
    output logic                  mem_request,
    output logic                  mem_we_re,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data_in,
    output logic [DATA_W/8-1:0]   mem_mask,
    input  logic                  mem_valid,
    input  logic [DATA_W-1:0]     mem_data_out,
    output logic                  err
);
    localparam int         MASK_W    = DATA_W / 8;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic       PORT_I    = 1'b0;
    localparam logic       PORT_D    = 1'b1;
    // last_grant starts on the port that should lose the first tie
    localparam logic       LAST_GRANT_RST = (DATA_FIRST != 0) ? PORT_I : PORT_D;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          cnt_inc;
    logic                mem_request_q, mem_request_d;
    logic                mem_we_re_q, mem_we_re_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
    logic [MASK_W-1:0]   mem_mask_q, mem_mask_d;
    logic                i_valid_q, i_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   i_data_out_q, i_data_out_d;
    logic [DATA_W-1:0]   d_data_out_q, d_data_out_d;
    logic                grant;

    // On a tie the port that did not win last time is served
    assign grant   = d_request && (!i_request || (last_grant_q == PORT_I)) ? PORT_D : PORT_I;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_request_d = 1'b0;
        mem_we_re_d   = mem_we_re_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_mask_d    = mem_mask_q;
        i_valid_d     = 1'b0;
        d_valid_d     = 1'b0;
        err_d         = 1'b0;
        i_data_out_d  = i_data_out_q;
        d_data_out_d  = d_data_out_q;

        case (state_q)
            S_IDLE: begin
                if (i_request || d_request) begin
                    owner_d       = grant;
                    last_grant_d  = grant;
                    mem_request_d = 1'b1;
                    state_d       = S_ISSUE;
                    if (grant == PORT_D) begin
                        mem_we_re_d   = d_we_re;
                        mem_address_d = d_address;
                        mem_data_in_d = d_data_in;
                        mem_mask_d    = d_mask;
                    end else begin
                        mem_we_re_d   = i_we_re;
                        mem_address_d = i_address;
                        mem_data_in_d = i_data_in;
                        mem_mask_d    = i_mask;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout is honoured
                if (mem_valid) begin
                    state_d = S_RESP;
                    if (owner_q == PORT_D) begin
                        d_valid_d = 1'b1;
                        if (!mem_we_re_q) d_data_out_d = mem_data_out;
                    end else begin
                        i_valid_d = 1'b1;
                        if (!mem_we_re_q) i_data_out_d = mem_data_out;
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_d   = cnt_inc;
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    if (owner_q == PORT_D) begin
                        d_valid_d    = 1'b1;
                        d_data_out_d = '0;
                    end else begin
                        i_valid_d    = 1'b1;
                        i_data_out_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= PORT_I;
            last_grant_q  <= LAST_GRANT_RST;
            cnt_q         <= 8'd0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_mask_q    <= '0;
            i_valid_q     <= 1'b0;
            d_valid_q     <= 1'b0;
            err_q         <= 1'b0;
            i_data_out_q  <= '0;
            d_data_out_q  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_mask_q    <= mem_mask_d;
            i_valid_q     <= i_valid_d;
            d_valid_q     <= d_valid_d;
            err_q         <= err_d;
            i_data_out_q  <= i_data_out_d;
            d_data_out_q  <= d_data_out_d;
        end
    end

    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_mask    = mem_mask_q;
    assign i_valid     = i_valid_q;
    assign d_valid     = d_valid_q;
    assign err         = err_q;
    assign i_data_out  = i_data_out_q;
    assign d_data_out  = d_data_out_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares one unified single-ported word memory between the core's instruction-fetch port and its load/store port.
- Sits between core and the memory top. It latches one transaction at a time, issues it to memory, and waits for memory valid.
- It routes read data back to the winner and pulses that requester's valid.
- Fairness is round-robin with a programmable priority after reset. A watchdog terminates hung transactions.

Parameters:
- ADDR_W, 12, word-address width (byte address bits [13:2]).
- DATA_W, 32, data width; mask width is DATA_W/8.
- TIMEOUT, 15, max cycles in WAIT before forced termination (1..255).
- DATA_FIRST, 1, 1 = data port wins the first tie after reset, 0 = instruction port wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_request  in  1  instruction port request; held high until i_valid.
- i_we_re  in  1  instruction port 1=write, 0=read.
- i_address  in  ADDR_W  instruction port word address.
- i_data_in  in  DATA_W  instruction port write data.
- i_mask  in  DATA_W/8  instruction port byte enables.
- i_valid  out  1  one-cycle completion pulse to instruction port.
- i_data_out  out  DATA_W  read data to instruction port.
- d_request, d_we_re, d_address, d_data_in, d_mask  in  (same widths)  data port request bundle.
- d_valid  out  1  one-cycle completion pulse to data port.
- d_data_out  out  DATA_W  read data to data port.
- mem_request  out  1  one-cycle request strobe to memory.
- mem_we_re  out  1  latched write/read select.
- mem_address  out  ADDR_W  latched address.
- mem_data_in  out  DATA_W  latched write data.
- mem_mask  out  DATA_W/8  latched mask.
- mem_valid  in  1  memory completion, at least 1 cycle after mem_request.
- mem_data_out  in  DATA_W  memory read data, sampled when mem_valid=1.
- err  out  1  high with the i_valid/d_valid pulse when the transaction timed out.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Timeout counter 0. last_grant = instruction if DATA_FIRST=1, else data.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests sampled on the clock edge.
  - Only one port requesting: it wins.
  - Both requesting: the port not equal to last_grant wins.
  - The winner's bundle is latched into mem_* registers, owner and last_grant are updated, and the FSM goes to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_request=1 for exactly this one cycle; go to WAIT; counter cleared.
- WAIT:
  - mem_valid=1: latch mem_data_out into the owner's *_data_out (reads only; writes leave *_data_out unchanged); err=0; go to RESP.
  - Else counter increments; at counter==TIMEOUT: go to RESP with err=1 and *_data_out=0.
  - mem_valid arriving in the same cycle as the timeout wins: normal completion, err=0.
- RESP: owner's *_valid=1 for exactly one cycle, plus err as latched. Requests are ignored in this state. Return to IDLE.
- The requester must deassert its request the cycle after its valid. A request still high in IDLE is treated as a new transaction.
- Latency: read completing with 1-cycle memory takes 4 cycles from the request-sample edge to the valid pulse. Back-to-back alternating grants issue every 4 cycles.
- mem_* bundle stays stable from ISSUE through RESP; mem_we_re/address/data/mask hold their last value while in IDLE.
- mem_valid outside WAIT is ignored.
- i_data_out/d_data_out hold their value until the next completion for that port.
- Never both i_valid and d_valid in one cycle.
- Changing the request bundle while the port is owned has no effect (latched copy used).

Test Plan:
- Single instruction read: i_request=1, i_address=12'h004, memory returns 32'h00500093 one cycle after mem_request → mem_request one cycle with mem_address=12'h004, mem_we_re=0; i_valid one cycle later with i_data_out=32'h00500093; d_valid stays 0; 4-cycle latency.
- Simultaneous requests after reset, DATA_FIRST=1: both held high → data granted first, then instruction; grants alternate D,I,D,I over four transactions; no cycle has both valids high.
- Data write: d_we_re=1, d_address=12'h010, d_data_in=32'hDEADBEEF, d_mask=4'b0011 → mem_* carries exactly those values; d_valid pulses; d_data_out unchanged.
- Timeout: mem_valid never asserted, TIMEOUT=15 → valid pulse with err=1 and data_out=0 after 15 WAIT cycles; next request is served normally with err=0.
- Reset mid-WAIT: assert rst asynchronously between edges → all outputs 0 immediately; FSM in IDLE; a later mem_valid produces no valid pulse.
- Bundle change while owned: change d_address during WAIT → mem_address keeps the latched value.
